// File: rtl/vga_video_out.sv
// VGA output stage: realigns raw sync counters to the draw-bit latency, derives
// active-low syncs, maps draw to frame-latched colours and registers every pin.
module vga_video_out #(
    parameter int unsigned VIDEO_WIDTH   = 3,
    parameter int unsigned TOTAL_COLS    = 800,
    parameter int unsigned TOTAL_ROWS    = 525,
    parameter int unsigned ACTIVE_COLS   = 640,
    parameter int unsigned ACTIVE_ROWS   = 480,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC_WIDTH  = 96,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC_WIDTH  = 2,
    parameter int unsigned DRAW_LATENCY  = 1
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic [9:0]                 i_Col_Count,
    input  logic [9:0]                 i_Row_Count,
    input  logic                       i_Draw,
    input  logic [3*VIDEO_WIDTH-1:0]   i_Fg_Rgb,
    input  logic [3*VIDEO_WIDTH-1:0]   i_Bg_Rgb,
    output logic                       o_VGA_HSync,
    output logic                       o_VGA_VSync,
    output logic [VIDEO_WIDTH-1:0]     o_Red,
    output logic [VIDEO_WIDTH-1:0]     o_Grn,
    output logic [VIDEO_WIDTH-1:0]     o_Blu,
    output logic                       o_Frame_Start
);

    localparam int unsigned RGB_W = 3 * VIDEO_WIDTH;

    localparam logic [9:0] C_TOTAL_COLS  = 10'(TOTAL_COLS);
    localparam logic [9:0] C_TOTAL_ROWS  = 10'(TOTAL_ROWS);
    localparam logic [9:0] C_ACTIVE_COLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] C_ACTIVE_ROWS = 10'(ACTIVE_ROWS);
    localparam logic [9:0] C_HS_FIRST    = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] C_HS_LAST     = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [9:0] C_VS_FIRST    = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] C_VS_LAST     = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

    logic [9:0]       w_DCol;
    logic [9:0]       w_DRow;
    logic             w_DValid;
    logic             w_In_Range;
    logic             w_Active;
    logic             w_HS_Low;
    logic             w_VS_Low;
    logic             w_Frame_Start;
    logic [RGB_W-1:0] w_Fg_Next;
    logic [RGB_W-1:0] w_Bg_Next;
    logic [RGB_W-1:0] w_Rgb_Next;

    logic [RGB_W-1:0] r_Fg;
    logic [RGB_W-1:0] r_Bg;
    logic [RGB_W-1:0] r_Rgb;
    logic             r_HSync;
    logic             r_VSync;
    logic             r_Frame_Start;

    // Delay line brings the counters into step with i_Draw.
    if (DRAW_LATENCY == 0) begin : g_bypass
        assign w_DCol   = i_Col_Count;
        assign w_DRow   = i_Row_Count;
        assign w_DValid = ~i_Rst;
    end else begin : g_pipe
        logic [9:0] r_Col_Pipe   [DRAW_LATENCY];
        logic [9:0] r_Row_Pipe   [DRAW_LATENCY];
        logic       r_Valid_Pipe [DRAW_LATENCY];

        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                for (int unsigned i = 0; i < DRAW_LATENCY; i++) begin
                    r_Col_Pipe[i]   <= '0;
                    r_Row_Pipe[i]   <= '0;
                    r_Valid_Pipe[i] <= 1'b0;
                end
            end else begin
                r_Col_Pipe[0]   <= i_Col_Count;
                r_Row_Pipe[0]   <= i_Row_Count;
                r_Valid_Pipe[0] <= 1'b1;
                for (int unsigned i = 1; i < DRAW_LATENCY; i++) begin
                    r_Col_Pipe[i]   <= r_Col_Pipe[i-1];
                    r_Row_Pipe[i]   <= r_Row_Pipe[i-1];
                    r_Valid_Pipe[i] <= r_Valid_Pipe[i-1];
                end
            end
        end

        assign w_DCol   = r_Col_Pipe[DRAW_LATENCY-1];
        assign w_DRow   = r_Row_Pipe[DRAW_LATENCY-1];
        assign w_DValid = r_Valid_Pipe[DRAW_LATENCY-1];
    end

    // Out-of-range counts count as blanking, so syncs stay high there.
    always_comb begin
        w_In_Range    = (w_DCol < C_TOTAL_COLS) && (w_DRow < C_TOTAL_ROWS);
        w_Active      = w_DValid && (w_DCol < C_ACTIVE_COLS) && (w_DRow < C_ACTIVE_ROWS);
        w_HS_Low      = w_DValid && w_In_Range && (w_DCol >= C_HS_FIRST) && (w_DCol <= C_HS_LAST);
        w_VS_Low      = w_DValid && w_In_Range && (w_DRow >= C_VS_FIRST) && (w_DRow <= C_VS_LAST);
        w_Frame_Start = w_DValid && (w_DCol == '0) && (w_DRow == '0);
        w_Fg_Next     = w_Frame_Start ? i_Fg_Rgb : r_Fg;
        w_Bg_Next     = w_Frame_Start ? i_Bg_Rgb : r_Bg;
        w_Rgb_Next    = '0;
        if (w_Active) begin
            w_Rgb_Next = i_Draw ? w_Fg_Next : w_Bg_Next;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Fg          <= '1;
            r_Bg          <= '0;
            r_Rgb         <= '0;
            r_HSync       <= 1'b1;
            r_VSync       <= 1'b1;
            r_Frame_Start <= 1'b0;
        end else begin
            r_Fg          <= w_Fg_Next;
            r_Bg          <= w_Bg_Next;
            r_Rgb         <= w_Rgb_Next;
            r_HSync       <= ~w_HS_Low;
            r_VSync       <= ~w_VS_Low;
            r_Frame_Start <= w_Frame_Start;
        end
    end

    assign o_VGA_HSync   = r_HSync;
    assign o_VGA_VSync   = r_VSync;
    assign o_Red         = r_Rgb[3*VIDEO_WIDTH-1:2*VIDEO_WIDTH];
    assign o_Grn         = r_Rgb[2*VIDEO_WIDTH-1:VIDEO_WIDTH];
    assign o_Blu         = r_Rgb[VIDEO_WIDTH-1:0];
    assign o_Frame_Start = r_Frame_Start;

endmodule

// File: tb/tb_vga_video_out.sv
// Directed bench for vga_video_out: three builds (draw latency 0, 1, 3) fed the same
// counter sequence, each with its own correctly delayed draw bit.
module tb_vga_video_out;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] col;
    logic [9:0] row;
    logic [8:0] fg;
    logic [8:0] bg;
    logic       drw [3];
    logic       hs  [3];
    logic       vs  [3];
    logic       fs  [3];
    logic [2:0] red [3];
    logic [2:0] grn [3];
    logic [2:0] blu [3];

    int n_checks = 0;
    int n_pass   = 0;
    int sidx     = 0;
    bit rec      = 1'b0;
    int hc [4];
    int lat [3] = '{0, 1, 3};

    int hs_low [3], vs_low [3], fs_cnt [3], fs_last [3], first_hs [3], first_vs [3];
    int c1c0 [3], c038 [3], c007 [3], czero [3], cother [3];

    always #5 clk = ~clk;

    vga_video_out #(.DRAW_LATENCY(0)) u_l0 (
        .i_Clk(clk), .i_Rst(rst), .i_Col_Count(col), .i_Row_Count(row), .i_Draw(drw[0]),
        .i_Fg_Rgb(fg), .i_Bg_Rgb(bg), .o_VGA_HSync(hs[0]), .o_VGA_VSync(vs[0]),
        .o_Red(red[0]), .o_Grn(grn[0]), .o_Blu(blu[0]), .o_Frame_Start(fs[0]));

    vga_video_out #(.DRAW_LATENCY(1)) u_l1 (
        .i_Clk(clk), .i_Rst(rst), .i_Col_Count(col), .i_Row_Count(row), .i_Draw(drw[1]),
        .i_Fg_Rgb(fg), .i_Bg_Rgb(bg), .o_VGA_HSync(hs[1]), .o_VGA_VSync(vs[1]),
        .o_Red(red[1]), .o_Grn(grn[1]), .o_Blu(blu[1]), .o_Frame_Start(fs[1]));

    vga_video_out #(.DRAW_LATENCY(3)) u_l3 (
        .i_Clk(clk), .i_Rst(rst), .i_Col_Count(col), .i_Row_Count(row), .i_Draw(drw[2]),
        .i_Fg_Rgb(fg), .i_Bg_Rgb(bg), .o_VGA_HSync(hs[2]), .o_VGA_VSync(vs[2]),
        .o_Red(red[2]), .o_Grn(grn[2]), .o_Blu(blu[2]), .o_Frame_Start(fs[2]));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int rgb_of(input int d);
        return int'({red[d], grn[d], blu[d]});
    endfunction

    // Draw pattern: left half of every line is foreground.
    task automatic step(input int c, input int r);
        col = 10'(c);
        row = 10'(r);
        for (int k = 3; k > 0; k--) hc[k] = hc[k-1];
        hc[0] = c;
        drw[0] = (hc[0] < 320);
        drw[1] = (hc[1] < 320);
        drw[2] = (hc[3] < 320);
        @(posedge clk);
        @(negedge clk);
        if (rec) begin
            for (int d = 0; d < 3; d++) begin
                if (!hs[d]) begin
                    hs_low[d]++;
                    if (first_hs[d] < 0) first_hs[d] = sidx;
                end
                if (!vs[d]) begin
                    vs_low[d]++;
                    if (first_vs[d] < 0) first_vs[d] = sidx;
                end
                if (fs[d]) begin
                    fs_cnt[d]++;
                    fs_last[d] = sidx;
                end
                case (rgb_of(d))
                    'h1C0:   c1c0[d]++;
                    'h038:   c038[d]++;
                    'h007:   c007[d]++;
                    'h000:   czero[d]++;
                    default: cother[d]++;
                endcase
            end
        end
        sidx++;
    endtask

    task automatic run_line(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) step(c, r);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            hs_low[d] = 0; vs_low[d] = 0; fs_cnt[d] = 0; fs_last[d] = -1;
            first_hs[d] = -1; first_vs[d] = -1;
            c1c0[d] = 0; c038[d] = 0; c007[d] = 0; czero[d] = 0; cother[d] = 0;
        end
        for (int k = 0; k < 4; k++) hc[k] = 0;
        rst = 1'b1;
        col = '0;
        row = '0;
        fg  = 9'h1C0;
        bg  = 9'h007;
        for (int d = 0; d < 3; d++) drw[d] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_hs", hs[1], 1);
        check("rst_vs", vs[1], 1);
        check("rst_rgb", rgb_of(1), 0);
        check("rst_fs", fs[1], 0);

        rst = 1'b0;
        rec = 1'b1;
        step(0, 0);
        check("l1_cyc1_fs", fs[1], 0);
        check("l1_cyc1_rgb", rgb_of(1), 0);
        check("l0_cyc1_fs", fs[0], 1);
        check("l3_cyc1_hs", hs[2], 1);
        step(1, 0);
        check("l1_cyc2_fs", fs[1], 1);
        check("l1_cyc2_rgb", rgb_of(1), 'h1C0);
        run_line(0, 2, 799);
        run_line(1, 0, 799);
        fg = 9'h038;
        run_line(100, 0, 799);
        for (int r = 488; r <= 493; r++) run_line(r, 0, 799);
        run_line(524, 0, 799);
        run_line(0, 0, 799);
        run_line(1, 0, 799);
        // Out-of-range counts flush the pipelines as blanking.
        repeat (4) step(1000, 1000);
        rec = 1'b0;

        for (int d = 0; d < 3; d++) begin
            check($sformatf("first_hs_L%0d", lat[d]), first_hs[d], 656 + lat[d]);
            check($sformatf("first_vs_L%0d", lat[d]), first_vs[d], 4000 + lat[d]);
            check($sformatf("fs_last_L%0d", lat[d]), fs_last[d], 8000 + lat[d]);
            check($sformatf("hs_low_L%0d", lat[d]), hs_low[d], 1152);
            check($sformatf("vs_low_L%0d", lat[d]), vs_low[d], 1600);
            check($sformatf("fs_cnt_L%0d", lat[d]), fs_cnt[d], 2);
            check($sformatf("rgb1c0_L%0d", lat[d]), c1c0[d], 960);
            check($sformatf("rgb038_L%0d", lat[d]), c038[d], 640);
            check($sformatf("rgb007_L%0d", lat[d]), c007[d], 1600);
            check($sformatf("rgb000_L%0d", lat[d]), czero[d], 6404);
            check($sformatf("rgbbad_L%0d", lat[d]), cother[d], 0);
        end

        fg = 9'h1C0;
        run_line(0, 0, 299);
        check("pre_rst_rgb", rgb_of(1), 'h1C0);
        rst = 1'b1;
        #1;
        check("async_rst_hs", hs[1], 1);
        check("async_rst_vs", vs[1], 1);
        check("async_rst_rgb_l1", rgb_of(1), 0);
        check("async_rst_rgb_l0", rgb_of(0), 0);
        check("async_rst_rgb_l3", rgb_of(2), 0);
        check("async_rst_fs", fs[1], 0);
        run_line(0, 300, 304);
        rst = 1'b0;
        step(305, 0);
        check("post_rst_l0_rgb", rgb_of(0), 'h1FF);
        check("post_rst_l1_hold", rgb_of(1), 0);
        step(306, 0);
        check("post_rst_l1_rgb", rgb_of(1), 'h1FF);
        step(307, 0);
        check("post_rst_l3_hold", rgb_of(2), 0);
        step(308, 0);
        check("post_rst_l3_rgb", rgb_of(2), 'h1FF);
        run_line(0, 309, 401);
        check("post_rst_bg", rgb_of(1), 0);
        check("post_rst_hs", hs[1], 1);
        run_line(0, 402, 799);
        fg = 9'h038;
        bg = 9'h005;
        step(0, 0);
        step(1, 0);
        check("relatch_fs", fs[1], 1);
        check("relatch_fg", rgb_of(1), 'h038);
        run_line(0, 2, 321);
        check("relatch_bg", rgb_of(1), 'h005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
